point_accumulator: RTL and testbench

- Upstream feeder for the 10-slot sum storage stage.
- Accumulates FRAMES consecutive ADC frames of POINTS samples each into a per-point sum array.
- Then streams the POINTS sums out in index order: out_index drives the storage stage's cnt_div and cnt_save selects the slot.
- After each completed slot, cnt_save advances modulo N_SLOTS, so the storage stage always writes the slot just produced.

---
 rtl/point_accumulator_if.sv | 35 +++
 rtl/point_accumulator.sv | 218 +++++++++++++++++++++
 tb/tb_point_accumulator.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/point_accumulator_if.sv
// Bundles the sample input, slot control and dump output signals of the
// point accumulator. The master side drives samples and control; the slave
// side is the accumulator.
interface point_accumulator_if #(
    parameter int unsigned DATA_W  = 14,
    parameter int unsigned SUM_W   = 24,
    parameter int unsigned IDX_W   = 11,
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned SLOT_W  = 4
);
    logic               start;
    logic               frame_start;
    logic               sample_valid;
    logic [DATA_W-1:0]  sample;
    logic [IDX_W-1:0]   POINTS;
    logic [FRAME_W-1:0] FRAMES;

    logic               busy;
    logic               out_valid;
    logic [IDX_W-1:0]   out_index;
    logic [SUM_W-1:0]   out_sum;
    logic               slot_done;
    logic [SLOT_W-1:0]  cnt_save;
    logic               err_short;

    modport master (
        output start, frame_start, sample_valid, sample, POINTS, FRAMES,
        input  busy, out_valid, out_index, out_sum, slot_done, cnt_save, err_short
    );

    modport slave (
        input  start, frame_start, sample_valid, sample, POINTS, FRAMES,
        output busy, out_valid, out_index, out_sum, slot_done, cnt_save, err_short
    );
endinterface

// File: rtl/point_accumulator.sv
// Accumulates FRAMES frames of POINTS ADC samples into a per-point sum array,
// then streams the sums out in index order and advances the storage slot
// counter so the downstream storage stage writes the slot just produced.
module point_accumulator #(
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned SUM_W      = 24,
    parameter int unsigned MAX_POINTS = 2048,
    parameter int unsigned N_SLOTS    = 10
) (
    input logic               clk,
    input logic               reset,
    point_accumulator_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(MAX_POINTS);
    localparam logic [3:0]  LAST_SLOT = 4'(N_SLOTS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitFrame,
        StAccum,
        StDump,
        StDone
    } state_t;

    state_t state_q;

    logic [IDX_W-1:0] points_q;
    logic [7:0]       frames_q;
    logic [7:0]       frame_cnt_q;
    logic [IDX_W-1:0] pt_cnt_q;
    logic [IDX_W-1:0] dump_addr_q;

    logic             busy_q;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_index_q;
    logic [SUM_W-1:0] out_sum_q;
    logic             slot_done_q;
    logic [3:0]       cnt_save_q;
    logic             err_short_q;

    logic [SUM_W-1:0] mem [MAX_POINTS];

    // Read/accumulate pipeline: stage 1 holds the sample whose read is in flight.
    logic             acc_en;
    logic [IDX_W-1:0] acc_addr;
    logic             acc_first;
    logic             p1_valid_q;
    logic [IDX_W-1:0] p1_addr_q;
    logic             p1_first_q;
    logic             p1_fwd_q;
    logic [DATA_W-1:0] p1_sample_q;
    logic [SUM_W-1:0] rd_data_q;
    logic [SUM_W-1:0] last_wr_q;
    logic [SUM_W-1:0] operand;
    logic [SUM_W-1:0] sample_ext;
    logic [SUM_W-1:0] wr_data;

    logic last_frame;
    logic frame_full;

    assign last_frame = (frame_cnt_q >= (frames_q - 8'd1));
    assign frame_full = (pt_cnt_q >= points_q);

    // Decide whether this cycle issues a read for an accepted sample.
    always_comb begin
        acc_en    = 1'b0;
        acc_addr  = '0;
        acc_first = 1'b0;
        unique case (state_q)
            StWaitFrame: begin
                if (bus.frame_start && bus.sample_valid) begin
                    acc_en    = 1'b1;
                    acc_first = (frame_cnt_q == 8'd0);
                end
            end
            StAccum: begin
                if (frame_full) begin
                    // Completed non-final frame; a coincident frame_start opens the next one.
                    acc_en = !last_frame && bus.frame_start && bus.sample_valid;
                end else if (bus.frame_start) begin
                    acc_en = bus.sample_valid;
                end else if (bus.sample_valid) begin
                    acc_en    = 1'b1;
                    acc_addr  = pt_cnt_q;
                    acc_first = (frame_cnt_q == 8'd0);
                end
            end
            default: ;
        endcase
    end

    // Add stage; with POINTS == 1 the same address can be read while it is
    // being written, so the previous write result is forwarded.
    always_comb begin
        sample_ext = {{(SUM_W - DATA_W){1'b0}}, p1_sample_q};
        operand    = p1_fwd_q ? last_wr_q : rd_data_q;
        wr_data    = p1_first_q ? sample_ext : operand + sample_ext;
    end

    // Pipeline control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_valid_q  <= 1'b0;
            p1_addr_q   <= '0;
            p1_first_q  <= 1'b0;
            p1_fwd_q    <= 1'b0;
            p1_sample_q <= '0;
            last_wr_q   <= '0;
        end else begin
            p1_valid_q  <= acc_en;
            p1_addr_q   <= acc_addr;
            p1_first_q  <= acc_first;
            p1_fwd_q    <= p1_valid_q && (p1_addr_q == acc_addr);
            p1_sample_q <= bus.sample;
            if (p1_valid_q) begin
                last_wr_q <= wr_data;
            end
        end
    end

    // Sum array: synchronous read for accumulation, write from the add stage.
    always_ff @(posedge clk) begin
        if (acc_en) begin
            rd_data_q <= mem[acc_addr];
        end
        if (p1_valid_q) begin
            mem[p1_addr_q] <= wr_data;
        end
    end

    // Slot sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            points_q    <= '0;
            frames_q    <= '0;
            frame_cnt_q <= '0;
            pt_cnt_q    <= '0;
            dump_addr_q <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_sum_q   <= '0;
            slot_done_q <= 1'b0;
            cnt_save_q  <= '0;
            err_short_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            slot_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && (bus.POINTS != '0)) begin
                        points_q    <= bus.POINTS;
                        frames_q    <= (bus.FRAMES == 8'd0) ? 8'd1 : bus.FRAMES;
                        frame_cnt_q <= '0;
                        pt_cnt_q    <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StWaitFrame;
                    end
                end
                StWaitFrame: begin
                    if (bus.frame_start) begin
                        pt_cnt_q <= bus.sample_valid ? IDX_W'(1) : '0;
                        state_q  <= StAccum;
                    end
                end
                StAccum: begin
                    if (frame_full) begin
                        if (last_frame) begin
                            // The final write lands on this edge, before the first dump read.
                            dump_addr_q <= '0;
                            state_q     <= StDump;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            if (bus.frame_start) begin
                                pt_cnt_q <= bus.sample_valid ? IDX_W'(1) : '0;
                            end else begin
                                pt_cnt_q <= '0;
                                state_q  <= StWaitFrame;
                            end
                        end
                    end else if (bus.frame_start) begin
                        err_short_q <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        pt_cnt_q    <= bus.sample_valid ? IDX_W'(1) : '0;
                    end else if (bus.sample_valid) begin
                        pt_cnt_q <= pt_cnt_q + IDX_W'(1);
                    end
                end
                StDump: begin
                    out_valid_q <= 1'b1;
                    out_index_q <= dump_addr_q;
                    out_sum_q   <= mem[dump_addr_q];
                    if (dump_addr_q == (points_q - IDX_W'(1))) begin
                        state_q <= StDone;
                    end else begin
                        dump_addr_q <= dump_addr_q + IDX_W'(1);
                    end
                end
                StDone: begin
                    slot_done_q <= 1'b1;
                    busy_q      <= 1'b0;
                    cnt_save_q  <= (cnt_save_q == LAST_SLOT) ? 4'd0 : cnt_save_q + 4'd1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.slot_done = slot_done_q;
    assign bus.cnt_save  = cnt_save_q;
    assign bus.err_short = err_short_q;
endmodule

// File: tb/tb_point_accumulator.sv
// Directed bench for point_accumulator: slot accumulation, dump stream,
// slot counter wrap, short frames, ignored samples, mid-dump reset and
// full-scale sums.
module tb_point_accumulator;
    logic clk = 1'b0;
    logic reset = 1'b1;

    point_accumulator_if bus ();

    point_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] cap_sum [$];
    logic [10:0] cap_idx [$];
    time         last_ov_t;
    logic [13:0] vec [8];

    // Capture every dump word.
    always @(posedge clk) begin
        #1;
        if (bus.out_valid === 1'b1) begin
            cap_sum.push_back(bus.out_sum);
            cap_idx.push_back(bus.out_index);
            last_ov_t = $time;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start        = 1'b0;
        bus.frame_start  = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cap_sum.delete();
        cap_idx.delete();
    endtask

    task automatic do_start(input int p, input int f);
        bus.POINTS = 11'(p);
        bus.FRAMES = 8'(f);
        bus.start  = 1'b1;
        cyc();
        bus.start  = 1'b0;
    endtask

    task automatic feed_frame(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_start  = (i == 0);
            bus.sample_valid = 1'b1;
            bus.sample       = vec[i];
            cyc();
        end
        idle_inputs();
    endtask

    task automatic wait_done(output bit seen, output bit busy_before);
        seen = 1'b0;
        busy_before = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            busy_before = bus.busy;
            cyc();
            if (bus.slot_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.slot_done !== 1'b0) begin n_err++; $display("FAIL reset_slot_done got %b want 0", bus.slot_done); end
        n_cmp++; if (bus.err_short !== 1'b0) begin n_err++; $display("FAIL reset_err_short got %b want 0", bus.err_short); end
        n_cmp++; if (bus.cnt_save !== 4'd0) begin n_err++; $display("FAIL reset_cnt_save got %0d want 0", bus.cnt_save); end
        n_cmp++; if (bus.out_index !== 11'd0 || bus.out_sum !== 24'd0) begin
            n_err++; $display("FAIL reset_out got idx %0d sum %0d want 0 0", bus.out_index, bus.out_sum);
        end
    endtask

    task automatic test_basic();
        bit seen, bb;
        logic [23:0] exp_sum [4] = '{24'd3, 24'd6, 24'd9, 24'd12};
        vec = '{14'd1, 14'd2, 14'd3, 14'd4, 14'd0, 14'd0, 14'd0, 14'd0};
        do_start(4, 3);
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", bus.busy); end
        for (int f = 0; f < 3; f++) feed_frame(4);
        wait_done(seen, bb);
        n_cmp++; if (!seen) begin n_err++; $display("FAIL basic_slot_done got timeout want pulse"); end
        n_cmp++; if (cap_sum.size() != 4) begin n_err++; $display("FAIL basic_count got %0d want 4", cap_sum.size()); end
        if (cap_sum.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (cap_idx[i] !== 11'(i) || cap_sum[i] !== exp_sum[i]) begin
                    n_err++;
                    $display("FAIL basic_word%0d got idx %0d sum %0d want idx %0d sum %0d",
                             i, cap_idx[i], cap_sum[i], i, exp_sum[i]);
                end
            end
        end
        n_cmp++; if ($time - last_ov_t != 10) begin n_err++; $display("FAIL basic_done_gap got %0t want 10", $time - last_ov_t); end
        n_cmp++; if (bus.busy !== 1'b0 || bb !== 1'b1) begin n_err++; $display("FAIL basic_busy_fall got %b/%b want 1/0", bb, bus.busy); end
        n_cmp++; if (bus.cnt_save !== 4'd1) begin n_err++; $display("FAIL basic_cnt_save got %0d want 1", bus.cnt_save); end
        cyc();
        n_cmp++; if (bus.slot_done !== 1'b0) begin n_err++; $display("FAIL basic_pulse_width got %b want 0", bus.slot_done); end
    endtask

    task automatic test_slot_wrap();
        bit seen, bb;
        reset_dut();
        vec = '{14'd7, 14'd8, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
        for (int k = 0; k < 10; k++) begin
            cap_sum.delete();
            do_start(2, 1);
            feed_frame(2);
            wait_done(seen, bb);
            n_cmp++;
            if (!seen || bus.cnt_save !== 4'((k + 1) % 10)) begin
                n_err++; $display("FAIL wrap_cnt_save%0d got %0d (seen %b) want %0d", k, bus.cnt_save, seen, (k + 1) % 10);
            end
            n_cmp++;
            if (bb !== 1'b1 || bus.busy !== 1'b0) begin
                n_err++; $display("FAIL wrap_busy%0d got %b/%b want 1/0", k, bb, bus.busy);
            end
        end
        n_cmp++;
        if (cap_sum.size() != 2 || cap_sum[0] !== 24'd7 || cap_sum[1] !== 24'd8) begin
            n_err++; $display("FAIL wrap_sums got %0d words want 7,8", cap_sum.size());
        end
    endtask

    task automatic test_back_to_back();
        bit seen, bb;
        // Single-point frames back to back re-read the address still being written.
        reset_dut();
        do_start(1, 3);
        vec[0] = 14'd5; feed_frame(1);
        vec[0] = 14'd6; feed_frame(1);
        vec[0] = 14'd7; feed_frame(1);
        wait_done(seen, bb);
        n_cmp++;
        if (!seen || cap_sum.size() != 1 || cap_sum[0] !== 24'd18) begin
            n_err++; $display("FAIL b2b_single_point got %0d words (seen %b) want one word 18", cap_sum.size(), seen);
        end
    endtask

    task automatic test_short_frame();
        bit seen, bb;
        reset_dut();
        do_start(4, 2);
        vec = '{14'd10, 14'd20, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
        feed_frame(2);
        vec = '{14'd1, 14'd2, 14'd3, 14'd4, 14'd0, 14'd0, 14'd0, 14'd0};
        feed_frame(4);
        n_cmp++; if (bus.err_short !== 1'b1) begin n_err++; $display("FAIL short_err got %b want 1", bus.err_short); end
        wait_done(seen, bb);
        n_cmp++; if (!seen || cap_sum.size() != 4) begin n_err++; $display("FAIL short_count got %0d want 4", cap_sum.size()); end
        if (cap_sum.size() == 4) begin
            n_cmp++; if (cap_sum[0] !== 24'd11) begin n_err++; $display("FAIL short_p0 got %0d want 11", cap_sum[0]); end
            n_cmp++; if (cap_sum[1] !== 24'd22) begin n_err++; $display("FAIL short_p1 got %0d want 22", cap_sum[1]); end
        end
    endtask

    task automatic test_frames_zero();
        bit seen, bb;
        cap_sum.delete();
        do_start(3, 0);
        vec = '{14'd5, 14'd6, 14'd7, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
        feed_frame(3);
        wait_done(seen, bb);
        n_cmp++;
        if (!seen || cap_sum.size() != 3 || cap_sum[0] !== 24'd5 || cap_sum[1] !== 24'd6 || cap_sum[2] !== 24'd7) begin
            n_err++; $display("FAIL frames0_sums got %0d words (seen %b) want 5,6,7", cap_sum.size(), seen);
        end
        n_cmp++; if (bus.cnt_save !== 4'd2) begin n_err++; $display("FAIL frames0_cnt_save got %0d want 2", bus.cnt_save); end
        n_cmp++; if (bus.err_short !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b want 1", bus.err_short); end
        cyc();
        do_start(0, 1);
        cyc();
        cyc();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL points0_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_dump();
        bit seen, bb;
        bit ov_seen;
        reset_dut();
        vec = '{14'd7, 14'd8, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
        for (int k = 0; k < 3; k++) begin
            do_start(2, 1);
            feed_frame(2);
            wait_done(seen, bb);
        end
        n_cmp++; if (bus.cnt_save !== 4'd3) begin n_err++; $display("FAIL mid_pre_cnt got %0d want 3", bus.cnt_save); end
        vec = '{14'd1, 14'd2, 14'd3, 14'd4, 14'd5, 14'd6, 14'd7, 14'd8};
        do_start(8, 1);
        feed_frame(8);
        ov_seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.out_valid === 1'b1) begin ov_seen = 1'b1; break; end
            cyc();
        end
        n_cmp++; if (!ov_seen) begin n_err++; $display("FAIL mid_dump_start got timeout want out_valid"); end
        cyc();
        reset = 1'b1;
        cyc();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.cnt_save !== 4'd0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got ov %b cnt %0d busy %b want 0 0 0", bus.out_valid, bus.cnt_save, bus.busy);
        end
        reset = 1'b0;
        cyc();
        cap_sum.delete();
        vec = '{14'd1, 14'd2, 14'd3, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
        do_start(3, 2);
        feed_frame(3);
        feed_frame(3);
        wait_done(seen, bb);
        n_cmp++;
        if (!seen || cap_sum.size() != 3 || cap_sum[0] !== 24'd2 || cap_sum[1] !== 24'd4 || cap_sum[2] !== 24'd6) begin
            n_err++; $display("FAIL mid_fresh_sums got %0d words (seen %b) want 2,4,6", cap_sum.size(), seen);
        end
        n_cmp++; if (bus.cnt_save !== 4'd1) begin n_err++; $display("FAIL mid_fresh_cnt got %0d want 1", bus.cnt_save); end
    endtask

    task automatic test_ignored_and_max();
        bit seen, bb;
        reset_dut();
        do_start(4, 2);
        bus.sample_valid = 1'b1;
        bus.sample       = 14'd999;
        cyc(); cyc(); cyc();
        idle_inputs();
        vec = '{14'd1, 14'd2, 14'd3, 14'd4, 14'd0, 14'd0, 14'd0, 14'd0};
        feed_frame(4);
        bus.sample_valid = 1'b1;
        bus.sample       = 14'd1000;
        for (int k = 0; k < 6; k++) cyc();
        idle_inputs();
        feed_frame(4);
        wait_done(seen, bb);
        n_cmp++;
        if (!seen || cap_sum.size() != 4 || cap_sum[0] !== 24'd2 || cap_sum[1] !== 24'd4 ||
            cap_sum[2] !== 24'd6 || cap_sum[3] !== 24'd8) begin
            n_err++; $display("FAIL ignored_sums got %0d words (seen %b) want 2,4,6,8", cap_sum.size(), seen);
        end
        cap_sum.delete();
        do_start(2, 255);
        vec[0] = 14'd16383;
        vec[1] = 14'd16383;
        for (int f = 0; f < 255; f++) feed_frame(2);
        wait_done(seen, bb);
        n_cmp++;
        if (!seen || cap_sum.size() != 2 || cap_sum[0] !== 24'd4177665 || cap_sum[1] !== 24'd4177665) begin
            n_err++; $display("FAIL max_sums got %0d words (seen %b) want 4177665 x2", cap_sum.size(), seen);
        end
    endtask

    initial begin
        idle_inputs();
        bus.POINTS = '0;
        bus.FRAMES = '0;
        test_reset();
        test_basic();
        test_slot_wrap();
        test_back_to_back();
        test_short_frame();
        test_frames_zero();
        test_reset_mid_dump();
        test_ignored_and_max();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
